// File: rtl/cpu_pkg.sv
// Shared register-bus definitions: widths, index type and the bus sequencer state
// encoding, so monitors and benches decode state the same way the controller does.
package cpu_pkg;
  localparam int XLEN     = 32;
  localparam int NUM_REGS = 32;
  localparam int IDX_W    = $clog2(NUM_REGS);

  typedef logic [IDX_W-1:0] reg_idx_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    EXEC  = 2'd2,
    WRITE = 2'd3
  } bus_state_t;
endpackage

// File: rtl/onehot_decoder.sv
// Index to one-hot select for the register buses. Purely combinational; index 0
// (the hardwired zero register) and out-of-range indices produce no select at all.
module onehot_decoder #(
  parameter int IDX_W = 5,
  parameter int N     = 32
) (
  input  logic             en,
  input  logic [IDX_W-1:0] idx,
  output logic [N-1:0]     onehot
);

  always_comb begin
    onehot = '0;
    if (en && (idx != '0) && (int'(idx) < N)) begin
      onehot[idx] = 1'b1;
    end
  end

endmodule

// File: rtl/reg_bus_controller.sv
// Initiator for the register array's operand buses: read rs1/rs2, hand operands to
// execute, wait (unbounded) for the result, write rd. Four cycles per op minimum.
module reg_bus_controller #(
  parameter int XLEN     = cpu_pkg::XLEN,
  parameter int NUM_REGS = cpu_pkg::NUM_REGS,
  parameter int IDX_W    = $clog2(NUM_REGS)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [IDX_W-1:0]    req_rs1,
  input  logic [IDX_W-1:0]    req_rs2,
  input  logic [IDX_W-1:0]    req_rd,
  output logic [NUM_REGS-1:0] enable_a,
  output logic [NUM_REGS-1:0] enable_b,
  output logic [NUM_REGS-1:0] store,
  output logic [XLEN-1:0]     store_value,
  input  logic [XLEN-1:0]     bus_a,
  input  logic [XLEN-1:0]     bus_b,
  output logic                op_valid,
  output logic [XLEN-1:0]     op_a,
  output logic [XLEN-1:0]     op_b,
  input  logic                result_valid,
  input  logic [XLEN-1:0]     result
);
  import cpu_pkg::*;

  bus_state_t       state_q, state_d;
  logic [IDX_W-1:0] rs1_q, rs1_d;
  logic [IDX_W-1:0] rs2_q, rs2_d;
  logic [IDX_W-1:0] rd_q, rd_d;
  logic [XLEN-1:0]  op_a_q, op_a_d;
  logic [XLEN-1:0]  op_b_q, op_b_d;
  logic [XLEN-1:0]  store_value_q, store_value_d;

  always_comb begin
    state_d       = state_q;
    rs1_d         = rs1_q;
    rs2_d         = rs2_q;
    rd_d          = rd_q;
    op_a_d        = op_a_q;
    op_b_d        = op_b_q;
    store_value_d = store_value_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          rs1_d   = req_rs1;
          rs2_d   = req_rs2;
          rd_d    = req_rd;
          state_d = READ;
        end
      end
      READ: begin
        // No select bit means nobody drives the bus: substitute zero instead of sampling it.
        op_a_d  = (|enable_a) ? bus_a : '0;
        op_b_d  = (|enable_b) ? bus_b : '0;
        state_d = EXEC;
      end
      EXEC: begin
        if (result_valid) begin
          store_value_d = result;
          state_d       = WRITE;
        end
      end
      WRITE:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      rs1_q         <= '0;
      rs2_q         <= '0;
      rd_q          <= '0;
      op_a_q        <= '0;
      op_b_q        <= '0;
      store_value_q <= '0;
    end else begin
      state_q       <= state_d;
      rs1_q         <= rs1_d;
      rs2_q         <= rs2_d;
      rd_q          <= rd_d;
      op_a_q        <= op_a_d;
      op_b_q        <= op_b_d;
      store_value_q <= store_value_d;
    end
  end

  // Selects decode only from registered state and indices, never from req_*.
  onehot_decoder #(.IDX_W(IDX_W), .N(NUM_REGS)) u_dec_a (
    .en     (state_q == READ),
    .idx    (rs1_q),
    .onehot (enable_a)
  );

  onehot_decoder #(.IDX_W(IDX_W), .N(NUM_REGS)) u_dec_b (
    .en     (state_q == READ),
    .idx    (rs2_q),
    .onehot (enable_b)
  );

  onehot_decoder #(.IDX_W(IDX_W), .N(NUM_REGS)) u_dec_store (
    .en     (state_q == WRITE),
    .idx    (rd_q),
    .onehot (store)
  );

  assign req_ready   = (state_q == IDLE) && !reset;
  assign op_valid    = (state_q == EXEC);
  assign op_a        = op_a_q;
  assign op_b        = op_b_q;
  assign store_value = store_value_q;

endmodule

// File: tb/tb_reg_bus_controller.sv
// Bench for reg_bus_controller: behavioural register array on the buses, an
// execute unit returning a+b after a programmable stall, and a store scoreboard.
module tb_reg_bus_controller;
  import cpu_pkg::*;

  logic                clk = 1'b0;
  logic                reset;
  logic                req_valid;
  logic                req_ready;
  logic [IDX_W-1:0]    req_rs1, req_rs2, req_rd;
  logic [NUM_REGS-1:0] enable_a, enable_b, store;
  logic [XLEN-1:0]     store_value, bus_a, bus_b, op_a, op_b, result;
  logic                op_valid, result_valid;

  int n_tests = 0;
  int n_fail  = 0;

  logic [XLEN-1:0] regs     [NUM_REGS];
  logic [XLEN-1:0] ref_regs [NUM_REGS];

  typedef struct packed {
    logic [IDX_W-1:0] rd;
    logic [XLEN-1:0]  val;
  } sb_t;
  sb_t sb_q[$];

  int stall_n  = 0;
  int ex_cnt   = 0;
  bit stray_rv = 1'b0;

  // Recognisable junk standing in for a floating bus.
  localparam logic [XLEN-1:0] FLOAT = 32'hBAD0_BAD0;

  always #5 clk = ~clk;

  reg_bus_controller dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_rs1      (req_rs1),
    .req_rs2      (req_rs2),
    .req_rd       (req_rd),
    .enable_a     (enable_a),
    .enable_b     (enable_b),
    .store        (store),
    .store_value  (store_value),
    .bus_a        (bus_a),
    .bus_b        (bus_b),
    .op_valid     (op_valid),
    .op_a         (op_a),
    .op_b         (op_b),
    .result_valid (result_valid),
    .result       (result)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always_comb begin
    bus_a = FLOAT;
    bus_b = FLOAT;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (enable_a[i]) bus_a = regs[i];
      if (enable_b[i]) bus_b = regs[i];
    end
  end

  always @(posedge clk) begin
    for (int i = 1; i < NUM_REGS; i++) begin
      if (store[i]) regs[i] = store_value;
    end
  end

  always @(negedge clk) begin
    if (op_valid) begin
      result_valid = (ex_cnt == stall_n);
      result       = op_a + op_b;
      ex_cnt++;
    end else begin
      result_valid = stray_rv;
      result       = 32'hFFFF_FFFF;
      ex_cnt       = 0;
    end
  end

  always @(negedge clk) begin
    sb_t e;
    if (!reset) begin
      check("onehot_inv",
            {61'b0, ($countones(enable_a) <= 1), ($countones(enable_b) <= 1), ($countones(store) <= 1)},
            64'h7);
      if (|store) begin
        if (sb_q.size() == 0) begin
          check("sb_unexpected_store", 64'(store), 64'h0);
        end else begin
          e = sb_q.pop_front();
          check("sb_store", 64'(store), 64'(1) << e.rd);
          check("sb_value", 64'(store_value), 64'(e.val));
        end
      end
    end
  end

  task automatic do_op(input int rs1, input int rs2, input int rd, input int stall, input bit b2b);
    logic [XLEN-1:0] a, b, s;
    logic [63:0]     ea, eb, es;
    int              guard;
    guard = 0;
    while (!req_ready && guard < 64) begin
      @(negedge clk);
      guard++;
    end
    check("req_ready_idle", 64'(req_ready), 64'h1);
    if (b2b) check("b2b_spacing", 64'(guard), 64'h0);
    a  = (rs1 != 0) ? ref_regs[rs1] : '0;
    b  = (rs2 != 0) ? ref_regs[rs2] : '0;
    s  = a + b;
    ea = (rs1 != 0) ? (64'(1) << rs1) : 64'h0;
    eb = (rs2 != 0) ? (64'(1) << rs2) : 64'h0;
    es = (rd != 0)  ? (64'(1) << rd)  : 64'h0;
    if (rd != 0) sb_q.push_back(sb_t'{IDX_W'(rd), s});
    stall_n   = stall;
    req_rs1   = IDX_W'(rs1);
    req_rs2   = IDX_W'(rs2);
    req_rd    = IDX_W'(rd);
    req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    check("c1_enable_a", 64'(enable_a), ea);
    check("c1_enable_b", 64'(enable_b), eb);
    check("c1_req_ready", 64'(req_ready), 64'h0);
    check("c1_op_valid", 64'(op_valid), 64'h0);
    check("c1_store", 64'(store), 64'h0);
    for (int k = 0; k <= stall; k++) begin
      @(negedge clk);
      check("exec_op_valid", 64'(op_valid), 64'h1);
      check("exec_op_a", 64'(op_a), 64'(a));
      check("exec_op_b", 64'(op_b), 64'(b));
      check("exec_no_enables", 64'(enable_a | enable_b | store), 64'h0);
    end
    @(negedge clk);
    check("wr_store", 64'(store), es);
    check("wr_value", 64'(store_value), 64'(s));
    check("wr_op_valid", 64'(op_valid), 64'h0);
    if (rd != 0) ref_regs[rd] = s;
    @(negedge clk);
    check("done_req_ready", 64'(req_ready), 64'h1);
    check("done_store", 64'(store), 64'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d failed=%0d", n_tests, n_fail);
    $fatal(1);
  end

  initial begin
    int guard;
    reset        = 1'b1;
    req_valid    = 1'b0;
    req_rs1      = '0;
    req_rs2      = '0;
    req_rd       = '0;
    result_valid = 1'b0;
    result       = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      regs[i]     = '0;
      ref_regs[i] = '0;
    end
    regs[3] = 32'hDEAD_BEEF; ref_regs[3] = 32'hDEAD_BEEF;
    regs[5] = 32'h0000_0011; ref_regs[5] = 32'h0000_0011;
    regs[6] = 32'h0000_0022; ref_regs[6] = 32'h0000_0022;
    regs[9] = 32'h0000_0001; ref_regs[9] = 32'h0000_0001;

    repeat (2) @(negedge clk);
    check("rst_enable_a", 64'(enable_a), 64'h0);
    check("rst_enable_b", 64'(enable_b), 64'h0);
    check("rst_store", 64'(store), 64'h0);
    check("rst_op_valid", 64'(op_valid), 64'h0);
    check("rst_op_a", 64'(op_a), 64'h0);
    check("rst_store_value", 64'(store_value), 64'h0);
    reset = 1'b0;
    @(negedge clk);
    check("rst_req_ready", 64'(req_ready), 64'h1);

    do_op(5, 6, 7, 0, 1'b0);
    check("r7_written", 64'(regs[7]), 64'h33);

    do_op(0, 3, 0, 0, 1'b0);

    do_op(5, 3, 10, 3, 1'b0);
    check("r10_written", 64'(regs[10]), 64'(32'hDEAD_BEEF + 32'h11));

    stray_rv = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("stray_req_ready", 64'(req_ready), 64'h1);
      check("stray_op_valid", 64'(op_valid), 64'h0);
    end
    stray_rv = 1'b0;
    @(negedge clk);
    check("stray_no_store", 64'(store), 64'h0);

    do_op(9, 9, 9, 0, 1'b0);
    check("r9_after_first", 64'(regs[9]), 64'h2);
    do_op(9, 9, 9, 0, 1'b1);
    check("r9_after_second", 64'(regs[9]), 64'h4);

    // Park an op in EXEC with a result that never arrives, then reset it.
    stall_n   = 1000;
    req_rs1   = IDX_W'(5);
    req_rs2   = IDX_W'(6);
    req_rd    = IDX_W'(11);
    req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    guard = 0;
    while (!op_valid && guard < 16) begin
      @(negedge clk);
      guard++;
    end
    check("mid_exec_op_valid", 64'(op_valid), 64'h1);
    reset = 1'b1;
    #1;
    check("mid_rst_enable_a", 64'(enable_a), 64'h0);
    check("mid_rst_enable_b", 64'(enable_b), 64'h0);
    check("mid_rst_store", 64'(store), 64'h0);
    check("mid_rst_op_valid", 64'(op_valid), 64'h0);
    check("mid_rst_op_a", 64'(op_a), 64'h0);
    check("mid_rst_op_b", 64'(op_b), 64'h0);
    check("mid_rst_store_value", 64'(store_value), 64'h0);
    check("mid_rst_req_ready", 64'(req_ready), 64'h0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check("post_rst_req_ready", 64'(req_ready), 64'h1);
    check("post_rst_no_write", 64'(regs[11]), 64'(ref_regs[11]));

    do_op(6, 5, 12, 1, 1'b0);

    check("sb_drained", 64'(sb_q.size()), 64'h0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
